// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480 raster timing constants, counter width and pipeline types
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync level while the pulse is active (0 = active-low)
    localparam logic VGA_SYNC_POL = 1'b0;

    typedef logic [CNT_W-1:0] cnt_t;

    // Timing flags carried alongside each pixel; all-zero is the idle/blank state
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } sync_t;

    localparam sync_t SYNC_IDLE = '0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // True when x lies in the half-open window [lo, lo+len)
    function automatic logic in_win(cnt_t x, int lo, int len);
        return (int'(x) >= lo) && (int'(x) < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_cnt.sv
// vga_sync_cnt: raster counters, registered active flag and raw sync/frame flags
module vga_sync_cnt
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic clk,
    input  logic rstb,
    output cnt_t h_c,
    output cnt_t v_c,
    output logic h_c_en,
    output logic hs_raw,
    output logic vs_raw,
    output logic fs_raw
);

    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);

    cnt_t h_c_q, h_c_d;
    cnt_t v_c_q, v_c_d;
    logic en_q, en_d;
    logic h_wrap;

    // Next raster position; the active flag is derived from it so it lands with its own counters
    always_comb begin
        h_wrap = (h_c_q == H_LAST);
        h_c_d  = h_wrap ? '0 : h_c_q + 1'b1;
        v_c_d  = !h_wrap ? v_c_q : ((v_c_q == V_LAST) ? '0 : v_c_q + 1'b1);
        en_d   = (int'(h_c_d) < H_ACTIVE) && (int'(v_c_d) < V_ACTIVE);
    end

    // Reset parks on the last pixel of the frame so the first clock after release presents (0,0)
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            h_c_q <= H_LAST;
            v_c_q <= V_LAST;
            en_q  <= 1'b0;
        end else begin
            h_c_q <= h_c_d;
            v_c_q <= v_c_d;
            en_q  <= en_d;
        end
    end

    // Raw sync windows decoded from the current counters; vsync spans whole lines
    always_comb begin
        hs_raw = in_win(h_c_q, H_ACTIVE + H_FP, H_SYNC);
        vs_raw = in_win(v_c_q, V_ACTIVE + V_FP, V_SYNC);
        fs_raw = (h_c_q == '0) && (v_c_q == '0);
    end

    assign h_c    = h_c_q;
    assign v_c    = v_c_q;
    assign h_c_en = en_q;

endmodule

// File: rtl/vga_sync_mix.sv
// vga_sync_mix: raster timing source, A-over-D compositor and sync-aligned VGA pin driver
module vga_sync_mix
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL
) (
    input  logic             clk,
    input  logic             rstb,
    output logic             h_c_en,
    output logic [CNT_W-1:0] v_c,
    output logic [CNT_W-1:0] h_c,
    input  logic             a_da_en,
    input  logic [7:0]       a_da_r,
    input  logic [7:0]       a_da_g,
    input  logic [7:0]       a_da_b,
    input  logic             d_da_en,
    input  logic [7:0]       d_da_r,
    input  logic [7:0]       d_da_g,
    input  logic [7:0]       d_da_b,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic             frame_sync
);

    logic  hs_raw, vs_raw, fs_raw;
    sync_t st1_q, st1_d;
    sync_t st2_q, st2_d;
    rgb_t  rgb_q, rgb_d;
    rgb_t  a_px, d_px;

    vga_sync_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_cnt (
        .clk    (clk),
        .rstb   (rstb),
        .h_c    (h_c),
        .v_c    (v_c),
        .h_c_en (h_c_en),
        .hs_raw (hs_raw),
        .vs_raw (vs_raw),
        .fs_raw (fs_raw)
    );

    assign a_px = {a_da_r, a_da_g, a_da_b};
    assign d_px = {d_da_r, d_da_g, d_da_b};

    // Stage 1 tracks the layer latency, stage 2 the mix register; RGB is blanked outside the active area
    always_comb begin
        st1_d = '{de: h_c_en, hs: hs_raw, vs: vs_raw, fs: fs_raw};
        st2_d = st1_q;
        rgb_d = !st1_q.de ? '0 : a_da_en ? a_px : d_da_en ? d_px : '0;
    end

    // Delay line and output colour register, cleared to idle so no partial sync survives a reset
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            st1_q <= SYNC_IDLE;
            st2_q <= SYNC_IDLE;
            rgb_q <= '0;
        end else begin
            st1_q <= st1_d;
            st2_q <= st2_d;
            rgb_q <= rgb_d;
        end
    end

    assign vga_r      = rgb_q.r;
    assign vga_g      = rgb_q.g;
    assign vga_b      = rgb_q.b;
    assign vga_de     = st2_q.de;
    assign vga_hs     = st2_q.hs ? SYNC_POL : ~SYNC_POL;
    assign vga_vs     = st2_q.vs ? SYNC_POL : ~SYNC_POL;
    assign frame_sync = st2_q.fs;

endmodule

// File: tb/tb_vga_sync_mix.sv
// tb_vga_sync_mix: scoreboard bench on a reduced-timing instance plus directed checks on a 640x480 instance
module tb_vga_sync_mix;

    localparam int SH_A = 64, SH_F = 8, SH_S = 12, SH_B = 8;
    localparam int SV_A = 20, SV_F = 3, SV_S = 2, SV_B = 4;
    localparam int S_HT = SH_A + SH_F + SH_S + SH_B;
    localparam int S_VT = SV_A + SV_F + SV_S + SV_B;

    typedef struct packed {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    int   cur_h, cur_v, prev_h, prev_v;

    logic       s_h_c_en, s_vga_hs, s_vga_vs, s_vga_de, s_fs;
    logic [9:0] s_h_c, s_v_c;
    logic [7:0] s_r, s_g, s_b;
    logic       s_a_en = 1'b0, s_d_en = 1'b0;
    logic [7:0] s_a_r = '0, s_a_g = '0, s_a_b = '0;
    logic [7:0] s_d_r = '0, s_d_g = '0, s_d_b = '0;

    logic       f_h_c_en, f_vga_hs, f_vga_vs, f_vga_de, f_fs;
    logic [9:0] f_h_c, f_v_c;
    logic [7:0] f_r, f_g, f_b;

    always #5 clk = ~clk;

    vga_sync_mix #(
        .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
        .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B)
    ) dut_s (
        .clk (clk), .rstb (rstb), .h_c_en (s_h_c_en), .v_c (s_v_c), .h_c (s_h_c),
        .a_da_en (s_a_en), .a_da_r (s_a_r), .a_da_g (s_a_g), .a_da_b (s_a_b),
        .d_da_en (s_d_en), .d_da_r (s_d_r), .d_da_g (s_d_g), .d_da_b (s_d_b),
        .vga_r (s_r), .vga_g (s_g), .vga_b (s_b), .vga_hs (s_vga_hs), .vga_vs (s_vga_vs),
        .vga_de (s_vga_de), .frame_sync (s_fs)
    );

    vga_sync_mix dut_f (
        .clk (clk), .rstb (rstb), .h_c_en (f_h_c_en), .v_c (f_v_c), .h_c (f_h_c),
        .a_da_en (1'b0), .a_da_r (8'd255), .a_da_g (8'd0), .a_da_b (8'd0),
        .d_da_en (1'b1), .d_da_r (8'd64), .d_da_g (8'd64), .d_da_b (8'd128),
        .vga_r (f_r), .vga_g (f_g), .vga_b (f_b), .vga_hs (f_vga_hs), .vga_vs (f_vga_vs),
        .vga_de (f_vga_de), .frame_sync (f_fs)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Expected pin state for a pixel at (h,v) given the layer pixels presented for it
    function automatic exp_t model(int h, int v, logic ae, logic [23:0] a, logic dn, logic [23:0] d);
        exp_t e;
        e.de  = (h < SH_A) && (v < SV_A);
        e.hs  = !((h >= SH_A + SH_F) && (h < SH_A + SH_F + SH_S));
        e.vs  = !((v >= SV_A + SV_F) && (v < SV_A + SV_F + SV_S));
        e.fs  = (h == 0) && (v == 0);
        e.rgb = !e.de ? 24'h0 : ae ? a : dn ? d : 24'h0;
        return e;
    endfunction

    task automatic restart_model();
        cur_h  = 0;
        cur_v  = 0;
        prev_h = S_HT - 1;
        prev_v = S_VT - 1;
        sb.push_back(model(prev_h, prev_v, 1'b0, 24'h0, 1'b0, 24'h0));
    endtask

    // Acts as the layer generators: one registered pixel per clock for the previous raster position
    task automatic drive(int n);
        logic ae, dn;
        logic [23:0] a, d;
        logic en_exp;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            en_exp = (cur_h < SH_A) && (cur_v < SV_A);
            check("s_counters", {11'h0, s_h_c, s_v_c, s_h_c_en}, {11'h0, 10'(cur_h), 10'(cur_v), en_exp});
            ae = ($urandom_range(0, 2) == 0);
            dn = ($urandom_range(0, 3) != 0);
            a  = 24'($urandom);
            d  = 24'($urandom);
            s_a_en = ae;
            s_a_r = a[23:16]; s_a_g = a[15:8]; s_a_b = a[7:0];
            s_d_en = dn;
            s_d_r = d[23:16]; s_d_g = d[15:8]; s_d_b = d[7:0];
            sb.push_back(model(prev_h, prev_v, ae, a, dn, d));
            prev_h = cur_h;
            prev_v = cur_v;
            cur_h  = cur_h + 1;
            if (cur_h == S_HT) begin
                cur_h = 0;
                cur_v = (cur_v + 1) % S_VT;
            end
        end
    endtask

    // Monitor: every clock the DUT presents one pixel; compare it against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_pixel", {4'h0, s_r, s_g, s_b, s_vga_de, s_vga_hs, s_vga_vs, s_fs},
                      {4'h0, e.rgb, e.de, e.hs, e.vs, e.fs});
            end
        end
    end

    // Directed line timing on the full 640x480 instance over the first two lines after release
    initial begin
        int n_en0, n656, hs_start, hs_len, fs_first, fs_cnt, bad_rgb, vs_low, wraps;
        int prev_hc;
        logic prev_hs;
        n_en0 = 0; n656 = -1; hs_start = -1; hs_len = 0; fs_first = -1; fs_cnt = 0;
        bad_rgb = 0; vs_low = 0; wraps = 0; prev_hc = -1; prev_hs = 1'b1;
        @(posedge rstb);
        for (int n = 1; n <= 1700; n++) begin
            @(posedge clk);
            #1;
            if (n == 1)
                check("f_first_pixel", {11'h0, f_h_c, f_v_c, f_h_c_en}, {11'h0, 10'd0, 10'd0, 1'b1});
            if (f_v_c == 10'd0 && f_h_c_en) n_en0++;
            if (f_h_c == 10'd656 && n656 < 0) n656 = n;
            if (!f_vga_hs && prev_hs && hs_start < 0) hs_start = n;
            if (!f_vga_hs && hs_start >= 0 && n < hs_start + 200) hs_len++;
            if (!f_vga_vs) vs_low++;
            if (f_fs) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
            end
            if (f_vga_de ? ({f_r, f_g, f_b} !== {8'd64, 8'd64, 8'd128}) : ({f_r, f_g, f_b} !== 24'h0)) bad_rgb++;
            if (prev_hc == 799) begin
                wraps++;
                check("f_wrap", {12'h0, f_h_c, f_v_c}, {12'h0, 10'd0, 10'(wraps)});
            end
            prev_hc = int'(f_h_c);
            prev_hs = f_vga_hs;
        end
        check("f_active_per_line", n_en0, 640);
        check("f_h656_cycle", n656, 657);
        check("f_hs_start", hs_start, n656 + 2);
        check("f_hs_width", hs_len, 96);
        check("f_vs_idle", vs_low, 0);
        check("f_fs_first", fs_first, 3);
        check("f_fs_count", fs_cnt, 1);
        check("f_rgb_bad", bad_rgb, 0);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("s_reset_cnt", {11'h0, s_h_c, s_v_c, s_h_c_en}, {11'h0, 10'(S_HT - 1), 10'(S_VT - 1), 1'b0});
        check("s_reset_pins", {4'h0, s_r, s_g, s_b, s_vga_de, s_vga_hs, s_vga_vs, s_fs}, {4'h0, 24'h0, 4'b0110});
        check("f_reset_cnt", {11'h0, f_h_c, f_v_c, f_h_c_en}, {11'h0, 10'd799, 10'd524, 1'b0});
        check("f_reset_pins", {4'h0, f_r, f_g, f_b, f_vga_de, f_vga_hs, f_vga_vs, f_fs}, {4'h0, 24'h0, 4'b0110});
        @(negedge clk);
        rstb = 1'b1;
        restart_model();
        drive(8101);
        check("s_pre_reset_de", {31'h0, s_vga_de}, 32'h1);
        #1;
        rstb = 1'b0;
        #1;
        sb.delete();
        check("s_async_reset_cnt", {11'h0, s_h_c, s_v_c, s_h_c_en}, {11'h0, 10'(S_HT - 1), 10'(S_VT - 1), 1'b0});
        check("s_async_reset_pins", {4'h0, s_r, s_g, s_b, s_vga_de, s_vga_hs, s_vga_vs, s_fs}, {4'h0, 24'h0, 4'b0110});
        check("f_async_reset_cnt", {11'h0, f_h_c, f_v_c, f_h_c_en}, {11'h0, 10'd799, 10'd524, 1'b0});
        check("f_async_reset_pins", {4'h0, f_r, f_g, f_b, f_vga_de, f_vga_hs, f_vga_vs, f_fs}, {4'h0, 24'h0, 4'b0110});
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
        restart_model();
        drive(400);
        repeat (2) @(posedge clk);
        #3;
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
